// File: rtl/l15_req_port_arbiter.sv
// N-port request arbiter feeding the tile L1.5 request channel: fixed-priority or
// round-robin selection, per-packet lock, starvation escalation, one registered output stage.

module l15_starve_cnt #(
    parameter int StarveTh = 64,
    parameter bit Enable   = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid,
    input  logic granted,
    input  logic last,
    input  logic blocked,
    output logic starved
);
    localparam logic [7:0] Th = 8'(StarveTh);

    logic [7:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || !Enable) begin
            cnt <= '0;
        end else if (granted && last) begin
            cnt <= '0;
        end else if (valid && !granted && !blocked && cnt != Th) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign starved = Enable && (cnt == Th);
endmodule

module l15_req_port_arbiter #(
    parameter int NumPorts   = 6,
    parameter int DataWidth  = 128,
    parameter int RoundRobin = 0,
    parameter int StarveTh   = 64,
    localparam int PidW      = $clog2(NumPorts)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumPorts-1:0]           req_valid_i,
    output logic [NumPorts-1:0]           req_ready_o,
    input  logic [NumPorts*DataWidth-1:0] req_data_i,
    input  logic [NumPorts-1:0]           req_last_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DataWidth-1:0]          out_data_o,
    output logic                          out_last_o,
    output logic [PidW-1:0]               out_portid_o,
    output logic                          lock_o,
    output logic [NumPorts-1:0]           starved_o
);
    localparam bit StarveEn = (RoundRobin == 0) && (StarveTh > 0);

    logic              lock_q;
    logic [PidW-1:0]   lock_pid;
    logic [PidW-1:0]   ptr_q;
    logic [PidW-1:0]   win;
    logic              found;
    int                idx;
    logic              win_valid;
    logic              win_last;
    logic [DataWidth-1:0] win_data;
    logic              adv;
    logic              accept;

    assign adv = ~out_valid_o | out_ready_i;

    // Winner selection never looks at out_ready_i; a lock pins the winner even when idle.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        if (lock_q) begin
            win   = lock_pid;
            found = 1'b1;
        end else if (RoundRobin != 0) begin
            for (int k = 0; k < NumPorts; k++) begin
                idx = (int'(ptr_q) + k) % NumPorts;
                if (!found && req_valid_i[PidW'(idx)]) begin
                    win   = PidW'(idx);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NumPorts; i++) begin
                if (!found && req_valid_i[i] && starved_o[i]) begin
                    win   = PidW'(i);
                    found = 1'b1;
                end
            end
            for (int i = 0; i < NumPorts; i++) begin
                if (!found && req_valid_i[i]) begin
                    win   = PidW'(i);
                    found = 1'b1;
                end
            end
        end
    end

    assign win_valid = req_valid_i[win];
    assign win_last  = req_last_i[win];
    assign win_data  = req_data_i[int'(win)*DataWidth +: DataWidth];
    assign accept    = win_valid & adv;

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < NumPorts; i++) begin
            req_ready_o[i] = accept & ~rst_i & (win == PidW'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o  <= 1'b0;
            out_data_o   <= '0;
            out_last_o   <= 1'b0;
            out_portid_o <= '0;
        end else if (accept) begin
            out_valid_o  <= 1'b1;
            out_data_o   <= win_data;
            out_last_o   <= win_last;
            out_portid_o <= win;
        end else if (out_ready_i) begin
            out_valid_o  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q   <= 1'b0;
            lock_pid <= '0;
            ptr_q    <= '0;
        end else if (accept) begin
            if (!win_last) begin
                lock_q   <= 1'b1;
                lock_pid <= win;
            end else begin
                lock_q <= 1'b0;
                ptr_q  <= (win == PidW'(NumPorts-1)) ? '0 : win + PidW'(1);
            end
        end
    end

    assign lock_o = lock_q;

    for (genvar g = 0; g < NumPorts; g++) begin : g_port
        l15_starve_cnt #(
            .StarveTh (StarveTh),
            .Enable   (StarveEn)
        ) u_cnt (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .valid   (req_valid_i[g]),
            .granted (accept && (win == PidW'(g))),
            .last    (req_last_i[g]),
            .blocked (lock_q && (lock_pid != PidW'(g))),
            .starved (starved_o[g])
        );
    end
endmodule
